// File: rtl/mem_pkg.sv
// Shared types and defaults for the data memory unit: access-size encodings,
// the clear/ready FSM state type and the default array geometry.
package mem_pkg;

    localparam int unsigned DEPTH_BYTES_DEF = 128;
    localparam int unsigned ADDR_BITS_DEF   = 7;
    localparam int unsigned DATA_W          = 32;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_memory_unit_if.sv
// CPU-side load/store bus of the data memory.
//   master (CPU): drives DAddr, DataIn, mRD, mWR, Size, LoadSigned
//   slave (memory): drives DataOut (combinational), Ready, MisalignErr, ErrAddr
interface data_memory_unit_if;
    import mem_pkg::*;

    logic [DATA_W-1:0] DAddr;
    logic [DATA_W-1:0] DataIn;
    logic              mRD;
    logic              mWR;
    logic [1:0]        Size;
    logic              LoadSigned;
    logic [DATA_W-1:0] DataOut;
    logic              Ready;
    logic              MisalignErr;
    logic [DATA_W-1:0] ErrAddr;

    modport master (
        output DAddr, DataIn, mRD, mWR, Size, LoadSigned,
        input  DataOut, Ready, MisalignErr, ErrAddr
    );

    modport slave (
        input  DAddr, DataIn, mRD, mWR, Size, LoadSigned,
        output DataOut, Ready, MisalignErr, ErrAddr
    );

endinterface

// File: rtl/mem_align_check.sv
// Combinational legality check for one access.
//   addr_lo_i : DAddr[1:0]
//   size_i    : access size encoding
//   legal_o   : access is naturally aligned and of a legal size
//   be_o      : byte enables, bit k = byte at word offset k (0 = MS byte);
//               all zero for an illegal access
module mem_align_check
    import mem_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [1:0] size_i,
    output logic       legal_o,
    output logic [3:0] be_o
);

    logic [3:0] be_raw;

    always_comb begin
        legal_o = 1'b0;
        be_raw  = 4'b0000;
        case (size_e'(size_i))
            SZ_BYTE: begin
                legal_o = 1'b1;
                be_raw  = 4'(4'b0001 << addr_lo_i);
            end
            SZ_HALF: begin
                legal_o = ~addr_lo_i[0];
                be_raw  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                legal_o = (addr_lo_i == 2'b00);
                be_raw  = 4'b1111;
            end
            default: begin
                legal_o = 1'b0;
                be_raw  = 4'b0000;
            end
        endcase
        be_o = legal_o ? be_raw : 4'b0000;
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressable, big-endian data memory with combinational loads,
// edge-committed stores, a post-reset clear sequencer and sticky error capture.
//   CLK, Reset : clock and asynchronous active-high reset
//   mem_bus    : slave side of the load/store bus (see data_memory_unit_if)
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    data_memory_unit_if.slave mem_bus
);

    localparam int unsigned WORDS    = DEPTH_BYTES / 4;
    localparam int unsigned IDX_BITS = ADDR_BITS - 2;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     err_addr_q, err_addr_d;

    logic [7:0]            mem_q [DEPTH_BYTES];

    logic                  legal;
    logic [3:0]            be;
    logic                  wr_en;
    logic [IDX_BITS-1:0]   word_idx;
    logic [1:0]            byte_off;
    logic [7:0]            wr_lane [4];
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_W-1:0]     ld_ext;

    assign word_idx = mem_bus.DAddr[ADDR_BITS-1:2];
    assign byte_off = mem_bus.DAddr[1:0];

    mem_align_check u_align (
        .addr_lo_i (byte_off),
        .size_i    (mem_bus.Size),
        .legal_o   (legal),
        .be_o      (be)
    );

    // Next-state: clear walk, then normal accesses with first-error capture
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        ready_d    = ready_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = IDX_BITS'(clr_idx_q + 1'b1);
                if (clr_idx_q == IDX_BITS'(WORDS - 1)) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                wr_en = mem_bus.mWR & legal;
                if ((mem_bus.mRD | mem_bus.mWR) && !legal && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = mem_bus.DAddr;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Store data steering: lane k receives the byte destined for word offset k
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            case (size_e'(mem_bus.Size))
                SZ_HALF: wr_lane[k] = ((k % 2) == 1) ? mem_bus.DataIn[7:0] : mem_bus.DataIn[15:8];
                SZ_WORD: wr_lane[k] = mem_bus.DataIn[8*(3-k) +: 8];
                default: wr_lane[k] = mem_bus.DataIn[7:0];
            endcase
        end
    end

    // Array has no reset; the clear walk defines its contents
    always_ff @(posedge CLK) begin
        if (state_q == ST_CLEAR) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{clr_idx_q, 2'(k)}] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[{word_idx, 2'(k)}] <= wr_lane[k];
                end
            end
        end
    end

    // Combinational load path, big-endian assembly and extension
    always_comb begin
        ld_byte = mem_q[{word_idx, byte_off}];
        ld_half = {mem_q[{word_idx, byte_off[1], 1'b0}], mem_q[{word_idx, byte_off[1], 1'b1}]};
        case (size_e'(mem_bus.Size))
            SZ_BYTE: ld_ext = {{24{mem_bus.LoadSigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{mem_bus.LoadSigned & ld_half[15]}}, ld_half};
            default: ld_ext = {mem_q[{word_idx, 2'd0}], mem_q[{word_idx, 2'd1}],
                               mem_q[{word_idx, 2'd2}], mem_q[{word_idx, 2'd3}]};
        endcase
    end

    assign mem_bus.DataOut     = ((state_q == ST_READY) && mem_bus.mRD && legal) ? ld_ext : '0;
    assign mem_bus.Ready       = ready_q;
    assign mem_bus.MisalignErr = err_q;
    assign mem_bus.ErrAddr     = err_addr_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed scenarios plus random
// loads/stores against a byte-array reference model.
module tb_data_memory_unit;
    import mem_pkg::*;

    localparam int unsigned DEPTH     = 128;
    localparam int unsigned CLR_EDGES = DEPTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_memory_unit_if bus ();

    data_memory_unit #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_BITS   (7)
    ) dut (
        .CLK     (clk),
        .Reset   (rst),
        .mem_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [7:0]  ref_mem [DEPTH];
    bit          ref_ready;
    bit          ref_err;
    logic [31:0] ref_err_addr;
    logic [31:0] d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b0;
        return (addr % nbytes(sz)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic sgn, input logic rd);
        int unsigned n, a;
        logic [31:0] v;
        if (!ref_ready || !rd || !ref_legal(addr, sz)) return 32'h0;
        n = nbytes(sz);
        a = addr % DEPTH;
        v = 32'h0;
        for (int unsigned i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(a + i) % DEPTH]);
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic idle_bus();
        bus.DAddr      = 32'h0;
        bus.DataIn     = 32'h0;
        bus.mRD        = 1'b0;
        bus.mWR        = 1'b0;
        bus.Size       = 2'b00;
        bus.LoadSigned = 1'b0;
    endtask

    // One bus cycle: drive, check combinational DataOut, clock, update model, check flags
    task automatic apply(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         output logic [31:0] dout);
        int unsigned n, a;
        bus.DAddr      = addr;
        bus.DataIn     = data;
        bus.mRD        = rd;
        bus.mWR        = wr;
        bus.Size       = sz;
        bus.LoadSigned = sgn;
        #2;
        dout = bus.DataOut;
        chk({tag, "/dout"}, dout, ref_load(addr, sz, sgn, rd));
        @(posedge clk);
        n = nbytes(sz);
        a = addr % DEPTH;
        if (ref_ready && wr && ref_legal(addr, sz))
            for (int unsigned i = 0; i < n; i++)
                ref_mem[(a + i) % DEPTH] = 8'(data >> (8*(n - 1 - i)));
        if (ref_ready && (rd || wr) && !ref_legal(addr, sz) && !ref_err) begin
            ref_err      = 1'b1;
            ref_err_addr = addr;
        end
        #1;
        idle_bus();
        chk({tag, "/err"}, 32'(bus.MisalignErr), 32'(ref_err));
        chk({tag, "/erraddr"}, bus.ErrAddr, ref_err_addr);
    endtask

    task automatic rand_op(input string tag, input int unsigned illegal_pct);
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] dout;
        sz   = ($urandom_range(0, 99) < illegal_pct) ? 2'd3 : 2'($urandom_range(0, 2));
        addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0 && sz != 2'd3) addr = addr & ~32'(nbytes(sz) - 1);
        apply(tag, addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              sz, 1'($urandom_range(0, 1)), dout);
    endtask

    // Reset, optional re-reset after abort_at clear edges, then the full clear walk
    task automatic reset_and_clear(input int unsigned abort_at, input bit poke);
        idle_bus();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst/ready", 32'(bus.Ready), 32'h0);
        chk("rst/err", 32'(bus.MisalignErr), 32'h0);
        chk("rst/erraddr", bus.ErrAddr, 32'h0);
        chk("rst/dout", bus.DataOut, 32'h0);
        ref_ready    = 1'b0;
        ref_err      = 1'b0;
        ref_err_addr = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
        rst = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            chk("abort/ready", 32'(bus.Ready), 32'h0);
            rst = 1'b1;
            #2;
            chk("abort/ready_rst", 32'(bus.Ready), 32'h0);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        for (int unsigned i = 0; i < CLR_EDGES; i++) begin
            chk("clear/ready", 32'(bus.Ready), 32'h0);
            if (poke) rand_op("clear_poke", 30);
            else begin
                @(posedge clk);
                #1;
            end
        end
        ref_ready = 1'b1;
        chk("clear/ready_rise", 32'(bus.Ready), 32'h1);
        chk("clear/err_clean", 32'(bus.MisalignErr), 32'h0);
    endtask

    initial begin
        idle_bus();
        ref_ready    = 1'b0;
        ref_err      = 1'b0;
        ref_err_addr = 32'h0;

        reset_and_clear(0, 1'b1);

        apply("ld7c", 32'h7C, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/ld7c", d, 32'h0);

        apply("st10", 32'h10, 32'h1234_5678, 1'b0, 1'b1, SZ_WORD, 1'b0, d);
        apply("lb10", 32'h10, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0, d);
        chk("plan/lb10", d, 32'h12);
        apply("lb13", 32'h13, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0, d);
        chk("plan/lb13", d, 32'h78);
        apply("lh12", 32'h12, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b1, d);
        chk("plan/lh12", d, 32'h0000_5678);

        apply("sb21", 32'h21, 32'hABCD_EFF0, 1'b0, 1'b1, SZ_BYTE, 1'b0, d);
        apply("lbs21", 32'h21, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b1, d);
        chk("plan/lbs21", d, 32'hFFFF_FFF0);
        apply("lbu21", 32'h21, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0, d);
        chk("plan/lbu21", d, 32'h0000_00F0);
        apply("lw20", 32'h20, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1, d);
        chk("plan/lw20", d, 32'h00F0_0000);

        apply("sw06", 32'h06, 32'hDEAD_BEEF, 1'b0, 1'b1, SZ_WORD, 1'b0, d);
        chk("plan/err1", 32'(bus.MisalignErr), 32'h1);
        chk("plan/erraddr1", bus.ErrAddr, 32'h06);
        apply("lh03", 32'h03, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0, d);
        chk("plan/lh03", d, 32'h0);
        chk("plan/erraddr2", bus.ErrAddr, 32'h06);
        apply("lw04", 32'h04, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/nowrite", d, 32'h0);

        apply("sw40", 32'h40, 32'h1111_1111, 1'b0, 1'b1, SZ_WORD, 1'b0, d);
        apply("rmw40", 32'h40, 32'hAAAA_5555, 1'b1, 1'b1, SZ_WORD, 1'b0, d);
        chk("plan/rmw_old", d, 32'h1111_1111);
        apply("lw40", 32'h40, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/rmw_new", d, 32'hAAAA_5555);

        apply("sw84", 32'h84, 32'hCAFE_F00D, 1'b0, 1'b1, SZ_WORD, 1'b0, d);
        apply("lw04w", 32'h04, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/wrap", d, 32'hCAFE_F00D);
        apply("lwhi", 32'hF000_0004, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/wrap_hi", d, 32'hCAFE_F00D);

        for (int i = 0; i < 400; i++) rand_op("rand1", 5);

        // Reset from READY, then again 10 edges into the clear walk
        reset_and_clear(10, 1'b0);
        apply("post_lw10", 32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/cleared10", d, 32'h0);
        apply("post_lw40", 32'h40, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, d);
        chk("plan/cleared40", d, 32'h0);

        for (int i = 0; i < 300; i++) rand_op("rand2", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
